mulnp_hs: RTL and testbench

MULNP_HS -- requirements
Module: mulnp_hs

---
 rtl/mulnp_hs.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mulnp_hs.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mulnp_hs.sv
// mulnp_hs: valid/ready pipelined W x W multiplier with selectable signedness.
// A Dadda bit-heap is reduced level by level, with the levels spread over STAGES.
module mulnp_hs #(
  parameter int W      = 32,
  parameter int STAGES = 3,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [1:0]      mode,
  input  logic [TAGW-1:0] tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    lo,
  output logic [W-1:0]    hi,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int C  = 2 * W;
  localparam int MH = W + 1;

  typedef logic [MH-1:0]     col_t;
  typedef col_t [C-1:0]      heap_t;
  typedef logic [C-1:0][7:0] hgt_t;

  function automatic int nlev(input int hmax);
    int k;
    int d;
    k = 0;
    d = 2;
    while (d < hmax) begin
      k++;
      d = d * 3 / 2;
    end
    return k;
  endfunction

  localparam int L = nlev(MH);

  function automatic int dval(input int l);
    int d;
    d = 2;
    for (int i = 0; i < L; i++)
      if (i < L - 1 - l) d = d * 3 / 2;
    return d;
  endfunction

  function automatic int lv(input int s);
    return (L * s) / STAGES;
  endfunction

  function automatic hgt_t init_hgt();
    hgt_t h;
    int   n;
    h = '0;
    for (int j = 0; j < C; j++) begin
      n = (j + 1 < W) ? j + 1 : W;
      if (j == W - 1) n++;
      h[j] = 8'(n);
    end
    return h;
  endfunction

  // Rows of a_ext * b; a negative b weight turns the top row into ~a_ext + 1.
  function automatic heap_t pp(input logic [W-1:0] ia,
                               input logic [W-1:0] ib,
                               input logic [1:0]   im);
    heap_t        h;
    logic [C-1:0] ax;
    logic         asg;
    logic         neg;
    int           k;
    asg = (im == 2'b01) || (im == 2'b10);
    neg = ((im == 2'b01) || (im == 2'b11)) && ib[W-1];
    ax  = asg ? {{W{ia[W-1]}}, ia} : {{W{1'b0}}, ia};
    h   = '0;
    for (int j = 0; j < C; j++) begin
      k = 0;
      for (int i = 0; i < W; i++) begin
        if (i <= j) begin
          if (i == W - 1 && neg) h[j][k] = ~ax[j-i];
          else                   h[j][k] = ib[i] & ax[j-i];
          k++;
        end
      end
      if (j == W - 1) h[j][k] = neg;
    end
    return h;
  endfunction

  function automatic void dlevel(input  heap_t hin,
                                 input  hgt_t  hh,
                                 input  int    d,
                                 output heap_t hout,
                                 output hgt_t  hoh);
    logic [2*MH-1:0] cmb;
    logic [2*MH-1:0] cv;
    logic [2*MH-1:0] nv;
    logic [2*MH-1:0] ov;
    int n;
    int cc;
    int nc;
    int t;
    int p;
    int o;
    hout = '0;
    hoh  = '0;
    cv   = '0;
    cc   = 0;
    for (int j = 0; j < C; j++) begin
      n   = int'(hh[j]);
      t   = n + cc;
      cmb = {{MH{1'b0}}, hin[j]};
      nv  = '0;
      ov  = '0;
      nc  = 0;
      o   = 0;
      p   = 0;
      for (int f = 0; f < MH; f++) begin
        if (t - d >= 2) begin
          ov[o]  = cmb[p] ^ cmb[p+1] ^ cmb[p+2];
          nv[nc] = (cmb[p] & cmb[p+1]) | (cmb[p+2] & (cmb[p] ^ cmb[p+1]));
          p += 3;
          o++;
          nc++;
          t -= 2;
        end else if (t - d == 1) begin
          ov[o]  = cmb[p] ^ cmb[p+1];
          nv[nc] = cmb[p] & cmb[p+1];
          p += 2;
          o++;
          nc++;
          t -= 1;
        end
      end
      ov      = ov | ((cmb >> p) << o);
      ov      = ov | (cv << (o + n - p));
      hout[j] = ov[MH-1:0];
      hoh[j]  = 8'(o + n - p + cc);
      cv      = nv;
      cc      = nc;
    end
  endfunction

  // Heights are tracked from the start so levels below l0 only cost constants.
  function automatic heap_t reduce(input heap_t h, input int l0, input int l1);
    heap_t cur;
    heap_t nxt;
    heap_t zh;
    hgt_t  hh;
    hgt_t  hn;
    cur = h;
    zh  = '0;
    hh  = init_hgt();
    for (int l = 0; l < L; l++) begin
      if (l < l1) begin
        dlevel((l >= l0) ? cur : zh, hh, dval(l), nxt, hn);
        if (l >= l0) cur = nxt;
        hh = hn;
      end
    end
    return cur;
  endfunction

  function automatic logic [C-1:0] fin(input heap_t h, input int l0);
    heap_t        f;
    logic [C-1:0] r0;
    logic [C-1:0] r1;
    f = reduce(h, l0, L);
    for (int j = 0; j < C; j++) begin
      r0[j] = f[j][0];
      r1[j] = f[j][1];
    end
    return r0 + r1;
  endfunction

  logic adv;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [1:0]      m_q;
  logic [TAGW-1:0] t0_q;
  logic            v0_q;

  heap_t           hc [STAGES];
  logic [TAGW-1:0] tc [STAGES];
  logic            vc [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= '0;
      t0_q <= '0;
      v0_q <= 1'b0;
    end else if (adv) begin
      a_q  <= a;
      b_q  <= b;
      m_q  <= mode;
      t0_q <= tag;
      v0_q <= in_valid;
    end
  end

  assign hc[0] = pp(a_q, b_q, m_q);
  assign tc[0] = t0_q;
  assign vc[0] = v0_q;

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    heap_t           h_d;
    heap_t           h_q;
    logic [TAGW-1:0] t_q;
    logic            v_q;

    assign h_d = reduce(hc[g-1], lv(g - 1), lv(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        h_q <= '0;
        t_q <= '0;
        v_q <= 1'b0;
      end else if (adv) begin
        h_q <= h_d;
        t_q <= tc[g-1];
        v_q <= vc[g-1];
      end
    end

    assign hc[g] = h_q;
    assign tc[g] = t_q;
    assign vc[g] = v_q;
  end

  logic [C-1:0]    p_d;
  logic [W-1:0]    lo_q;
  logic [W-1:0]    hi_q;
  logic [TAGW-1:0] ot_q;
  logic            ov_q;

  assign p_d = fin(hc[STAGES-1], lv(STAGES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
      ot_q <= '0;
      ov_q <= 1'b0;
    end else if (adv) begin
      lo_q <= p_d[W-1:0];
      hi_q <= p_d[C-1:W];
      ot_q <= tc[STAGES-1];
      ov_q <= vc[STAGES-1];
    end
  end

  assign lo        = lo_q;
  assign hi        = hi_q;
  assign out_tag   = ot_q;
  assign out_valid = ov_q;

  always_comb begin
    busy = ov_q;
    for (int g = 0; g < STAGES; g++)
      busy = busy | vc[g];
  end

endmodule

// File: tb/tb_mulnp_hs.sv
// tb_mulnp_hs: scoreboard bench for mulnp_hs, directed corners and reset
// cases plus a random phase with random gaps and downstream back-pressure.
`timescale 1ns/1ps
module tb_mulnp_hs;
  localparam int W  = 32;
  localparam int ST = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    mode = '0;
  logic [TW-1:0] tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic [TW-1:0] out_tag;
  logic          busy;

  logic       v8 = 1'b0;
  logic       r8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [1:0] m8 = '0;
  logic [3:0] t8 = '0;
  logic       ov8;
  logic [7:0] lo8;
  logic [7:0] hi8;
  logic [3:0] ot8;
  logic       busy8;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  typedef struct {
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sq[$];
  exp_t me;

  mulnp_hs #(.W(W), .STAGES(ST), .TAGW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .lo(lo), .hi(hi), .out_tag(out_tag), .busy(busy)
  );

  mulnp_hs #(.W(8), .STAGES(1), .TAGW(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(r8),
    .a(a8), .b(b8), .mode(m8), .tag(t8),
    .out_valid(ov8), .out_ready(1'b1),
    .lo(lo8), .hi(hi8), .out_tag(ot8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic [1:0]   m);
    logic signed [65:0] sx;
    logic signed [65:0] sy;
    logic signed [65:0] pr;
    sx = (m == 2'b01 || m == 2'b10) ? {{34{x[W-1]}}, x} : {34'b0, x};
    sy = (m == 2'b01 || m == 2'b11) ? {{34{y[W-1]}}, y} : {34'b0, y};
    pr = sx * sy;
    return pr[63:0];
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got tag %0d lo %0h hi %0h, want no result",
                 out_tag, lo, hi);
      end else begin
        me = sq.pop_front();
        chk("sb_tag", 64'(out_tag), 64'(me.tag));
        chk("sb_lo", 64'(lo), 64'(me.lo));
        chk("sb_hi", 64'(hi), 64'(me.hi));
      end
    end
  end

  task automatic send_exp(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [1:0] im, input logic [TW-1:0] it,
                          input logic [W-1:0] el, input logic [W-1:0] eh,
                          output int waited);
    exp_t e;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    mode     = im;
    tag      = it;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (in_ready) begin
      e.lo  = el;
      e.hi  = eh;
      e.tag = it;
      sq.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      chk("accept_timeout", 64'(waited), 64'd0);
    end
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    mode     = 2'($urandom);
    tag      = TW'($urandom);
  endtask

  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [1:0] im, input logic [TW-1:0] it);
    logic [63:0] p;
    int          w;
    p = model(ia, ib, im);
    send_exp(ia, ib, im, it, p[31:0], p[63:32], w);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sq.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          w;
    logic [W-1:0] xa [5];
    logic [W-1:0] xb [5];
    logic [1:0]   xm [5];
    logic [63:0]  p1;

    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send_exp(32'd292, 32'd6785, 2'b00, 4'd1, 32'd1981220, 32'd0, w);
    chk("accept_after_rst", 64'(w), 64'd0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    chk("latency", 64'(n), 64'(ST));
    drain();

    send_exp(32'hFFFF_FFFF, 32'd2, 2'b00, 4'd2, 32'hFFFF_FFFE, 32'h0000_0001, w);
    send_exp(32'hFFFF_FFFF, 32'd2, 2'b01, 4'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, w);
    send_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'd4, 32'h0000_0001,
             32'hFFFF_FFFF, w);
    send_exp(32'h8000_0000, 32'h8000_0000, 2'b01, 4'd5, 32'h0, 32'h4000_0000, w);
    send_exp(32'd2, 32'hFFFF_FFFF, 2'b11, 4'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, w);
    drain();

    for (int i = 1; i <= 4; i++) begin
      xa[i] = $urandom;
      xb[i] = $urandom;
      xm[i] = 2'($urandom);
      send(xa[i], xb[i], xm[i], TW'(i));
    end
    chk("stall_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    p1 = model(xa[1], xb[1], xm[1]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_tag", 64'(out_tag), 64'd1);
      chk("stall_lo", 64'(lo), 64'(p1[31:0]));
      chk("stall_hi", 64'(hi), 64'(p1[63:32]));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    send($urandom, $urandom, 2'b01, 4'd7);
    send($urandom, $urandom, 2'b00, 4'd8);
    @(posedge clk);
    #1 rst = 1'b1;
    sq.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_quiet_valid", 64'(out_valid), 64'd0);
    chk("postrst_quiet_busy", 64'(busy), 64'd0);
    send_exp(32'd7, 32'd9, 2'b00, 4'd9, 32'd63, 32'd0, w);
    chk("accept_first_edge", 64'(w), 64'd0);
    drain();

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 2'($urandom), TW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    v8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    m8 = 2'b00;
    t8 = 4'd3;
    @(negedge clk);
    chk("w8_ready", 64'(r8), 64'd1);
    @(posedge clk);
    #1;
    v8 = 1'b1;
    m8 = 2'b01;
    t8 = 4'd5;
    chk("w8_early", 64'(ov8), 64'd0);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    chk("w8_uu_valid", 64'(ov8), 64'd1);
    chk("w8_uu_lo", 64'(lo8), 64'h01);
    chk("w8_uu_hi", 64'(hi8), 64'hFE);
    chk("w8_uu_tag", 64'(ot8), 64'd3);
    @(posedge clk);
    #1;
    chk("w8_ss_valid", 64'(ov8), 64'd1);
    chk("w8_ss_lo", 64'(lo8), 64'h01);
    chk("w8_ss_hi", 64'(hi8), 64'h00);
    chk("w8_ss_tag", 64'(ot8), 64'd5);
    @(posedge clk);
    #1;
    chk("w8_idle", 64'(busy8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
